// File: rtl/uart_pkg.sv
// Shared state encoding and frame/watchdog sizing for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        SEND  = 2'd2,
        WAIT  = 2'd3
    } arb_state_e;

    localparam int TIMEOUT_MULT = 2;

    // Clocks per frame: start + 8 data + parity + stop bits, truncated.
    function automatic int frame_clks(input longint clk_hz, input longint baud,
                                      input longint parity, input longint stop);
        return int'((10 + parity + stop - 1) * clk_hz / baud);
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: lowest valid index at or after rr_ptr, wrapping.
module uart_rr_picker #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [PW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] winner,
    output logic             any
);

    always_comb begin
        winner = '0;
        // Scan farthest-to-nearest so the candidate closest to rr_ptr is written last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                winner = '0;
                winner[(int'(rr_ptr) + k) % N_REQ] = 1'b1;
            end
        end
    end

    assign any = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte producers,
// holding the grant for a whole message and recovering via a watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int CLK_FREQ_HZ = 33330000,
    parameter int BAUD_RATE   = 115200,
    parameter int PARITY      = 0,
    parameter int STOP        = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_byte,
    output logic               send_byte,
    input  logic               byte_sent,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               timeout_err
);

    localparam int FRAME_CLKS   = frame_clks(CLK_FREQ_HZ, BAUD_RATE, PARITY, STOP);
    localparam int TIMEOUT_CLKS = TIMEOUT_MULT * FRAME_CLKS;
    localparam int TW           = $clog2(TIMEOUT_CLKS + 1);
    localparam int PW           = $clog2(N_REQ);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             lock_last_q, lock_last_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             send_byte_q, timeout_err_q, timeout_err_d, busy_q;

    logic [N_REQ-1:0] winner;
    logic             any_valid;
    logic [7:0]       sel_data;
    logic             sel_last, sel_valid;
    logic [PW-1:0]    ptr_after;

    uart_rr_picker #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .winner    (winner),
        .any       (any_valid)
    );

    // Owner's lane and the pointer position just past the owner.
    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        ptr_after = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                sel_data  = req_data[8*i +: 8];
                sel_last  = req_last[i];
                sel_valid = req_valid[i];
                ptr_after = (i == N_REQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    assign req_ready = (state_q == ISSUE) ? (grant_q & req_valid) : '0;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        tx_byte_d     = tx_byte_q;
        lock_last_d   = lock_last_q;
        timer_d       = timer_q;
        timeout_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d = winner;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (sel_valid) begin
                    tx_byte_d   = sel_data;
                    lock_last_d = sel_last;
                    state_d     = SEND;
                end else begin
                    grant_d  = '0;
                    rr_ptr_d = ptr_after;
                    state_d  = IDLE;
                end
            end
            SEND: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                // A completion on the expiry cycle takes priority over the watchdog.
                if (byte_sent) begin
                    if (lock_last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = ptr_after;
                        state_d  = IDLE;
                    end else begin
                        state_d = ISSUE;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    timeout_err_d = 1'b1;
                    grant_d       = '0;
                    rr_ptr_d      = ptr_after;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            tx_byte_q     <= '0;
            lock_last_q   <= 1'b0;
            timer_q       <= '0;
            send_byte_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            tx_byte_q     <= tx_byte_d;
            lock_last_q   <= lock_last_d;
            timer_q       <= timer_d;
            send_byte_q   <= (state_d == SEND);
            timeout_err_q <= timeout_err_d;
            busy_q        <= (state_d != IDLE);
        end
    end

    assign grant       = grant_q;
    assign tx_byte     = tx_byte_q;
    assign send_byte   = send_byte_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `UART_TX_simple` transmitter among `N_REQ` byte producers. It accepts bytes over per-requester valid/ready handshakes and issues single-cycle `send_byte` strobes with `tx_byte`. It then waits for `byte_sent` before issuing the next byte. A requester keeps the grant until it sends a byte marked last. A watchdog recovers the arbiter if `byte_sent` never arrives.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `CLK_FREQ_HZ`, 33330000, clock frequency; must match the transmitter instance
- `BAUD_RATE`, 115200, transmitter baud rate
- `PARITY`, 0, 1 if the transmitter sends a parity bit
- `STOP`, 1, number of stop bits

Ports (one clock `clk`; reset `rst_n` is asynchronous and active-low):
- `clk`  in  1  system clock; all state changes on its rising edge
- `rst_n`  in  1  async active-low reset
- `req_valid`  in  N_REQ  requester i has a byte on its data lane
- `req_data`  in  8*N_REQ  byte of requester i on bits [8i+7:8i]
- `req_last`  in  N_REQ  byte of requester i is the final byte of its message
- `req_ready`  out  N_REQ  one-hot; byte of requester i is accepted this cycle
- `tx_byte`  out  8  byte to transmitter
- `send_byte`  out  1  one-cycle start strobe to transmitter
- `byte_sent`  in  1  one-cycle completion pulse from transmitter
- `grant`  out  N_REQ  one-hot current owner; 0 when idle
- `busy`  out  1  1 whenever state is not IDLE
- `timeout_err`  out  1  one-cycle pulse on watchdog expiry

## Operation
- Frame and watchdog sizes:
  - FRAME_CLKS = (10+PARITY+STOP-1)*CLK_FREQ_HZ/BAUD_RATE, integer division.
  - TIMEOUT_CLKS = 2*FRAME_CLKS; defaults give 5786.
  - Timer width is clog2(TIMEOUT_CLKS+1).
- Round-robin pointer `rr_ptr` (0..N_REQ-1): the winner is the lowest index ≥ `rr_ptr` with `req_valid` set, wrapping modulo N_REQ.
- States:
  - IDLE: `grant`=0. If any `req_valid` is set, register the one-hot winner into `grant` and go to ISSUE.
  - ISSUE (1 cycle), owner g:
    - If `req_valid[g]`=1: `req_ready[g]`=1 combinationally, latch `req_data[g]` into `tx_byte` and `req_last[g]` into `lock_last`, then go to SEND.
    - If `req_valid[g]`=0: clear `grant`, set `rr_ptr`=g+1 mod N_REQ, go to IDLE; nothing is sent.
  - SEND (1 cycle): `send_byte`=1, clear the timer, go to WAIT.
  - WAIT: timer increments every cycle.
    - On `byte_sent` with `lock_last`=0: go to ISSUE with the same grant.
    - On `byte_sent` with `lock_last`=1: clear `grant`, set `rr_ptr`=g+1 mod N_REQ, go to IDLE.
    - When timer==TIMEOUT_CLKS-1 and there is no `byte_sent`: pulse `timeout_err`, clear `grant`, advance `rr_ptr`, go to IDLE.
- Boundary cases:
  - `byte_sent` together with watchdog expiry: `byte_sent` wins and there is no error.
  - `byte_sent` in any state other than WAIT is ignored.
  - `req_valid` changing outside ISSUE has no effect on the current transfer.
  - The pointer wraps from N_REQ-1 to 0.
- Reset values: all outputs 0, state IDLE, `rr_ptr`=0, timer 0, `lock_last`=0.
  - A reset in the middle of a transfer aborts it immediately.
  - The transmitter shares `rst_n`, so no frame survives the reset.

## Timing
- `grant`, `tx_byte`, `send_byte`, `busy` and `timeout_err` are registered; `req_ready` is combinational from state, `grant` and `req_valid`.
- From `req_valid` sampled in IDLE at edge t:
  - `grant` and `req_ready` are high during cycle t+1.
  - `send_byte` is high during cycle t+2, with `tx_byte` already stable.
- Within a message: `byte_sent` at cycle b → `req_ready` at b+1 → `send_byte` at b+2.
- Watchdog: with `send_byte` at cycle s, WAIT covers cycles s+1..s+TIMEOUT_CLKS and `timeout_err` pulses at s+TIMEOUT_CLKS+1.
- `tx_byte` holds its value until the next ISSUE.

## Structure
- Package `uart_pkg` holds:
  - state encoding localparams IDLE=0, ISSUE=1, SEND=2, WAIT=3
  - function `frame_clks(clk_hz, baud, parity, stop)`
  - the TIMEOUT multiplier 2
- Sub-module `uart_rr_picker` (combinational): inputs `req_valid` and `rr_ptr`; outputs one-hot `winner` and `any`. The arbiter FSM, the timer and the data mux live in the top level.

## Test plan
The bench uses CLK_FREQ_HZ=1000000 and BAUD_RATE=100000, which gives FRAME_CLKS=100 and TIMEOUT_CLKS=200. The transmitter model returns `byte_sent` 100 cycles after `send_byte`.

1. Single byte: req0 sends 0x88 with last=1 → `grant`=0001 and `req_ready[0]` at t+1; `send_byte` with `tx_byte`=0x88 at t+2; `grant`=0 and `busy`=0 one cycle after `byte_sent`.
2. All four requesters valid with single-byte messages 0x11/0x22/0x33/0x44 → bytes are sent in order 0,1,2,3. A second round starts again at req0.
3. Locked message: req1 sends 0xA0, 0xA1, 0xA2 (last on 0xA2) while req2 is valid → req2 is granted only after the `byte_sent` for 0xA2. Each gap from `byte_sent` to `send_byte` is 2 cycles.
4. Watchdog:
   - Model suppresses `byte_sent` → `timeout_err` is a single pulse at s+201, then `grant`=0 and the next requester is served.
   - `byte_sent` at exactly s+200 → no error.
5. Withdrawal: req3 drops `req_valid` in its ISSUE cycle → no `send_byte`, `grant` returns to 0, and `rr_ptr` becomes 0.
6. Reset: `rst_n` is pulled low in WAIT → all outputs are 0 within the same cycle, asynchronously. After release, a stray `byte_sent` causes no state change.
